muldiv_ctrl: RTL and testbench

- Multi-cycle multiply/divide sequencer and owner of the architectural HI/LO registers.
- Sits beside the EXE stage. It takes MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO requests decoded in ID (alu_op[19:12]).
- It runs an iterative radix-2 divider and a fixed-latency multiplier, and back-pressures EXE through req_ready while an operation is in flight.
- flush from CP0 cancels any in-flight operation.

---
 rtl/muldiv_ctrl.sv | 164 ++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// HI/LO owner for the EXE stage: fixed-latency multiplier, radix-2 restoring divider,
// and MFHI/MFLO/MTHI/MTLO handling, with back-pressure while an operation is in flight.
module muldiv_ctrl #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        req_valid,
  input  logic [7:0]  req_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        req_ready,
  output logic        busy,
  output logic [31:0] rd_data,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  localparam logic [4:0] MUL_CNT_INIT = 5'(MUL_LAT - 1);

  state_t      r_state;
  state_t      w_nextState;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_opA;
  logic [31:0] r_opB;
  logic [31:0] r_rem;
  logic [31:0] r_rawA;
  logic [4:0]  r_cnt;
  logic        r_mulSigned;
  logic        r_negQ;
  logic        r_negR;
  logic        r_divZero;

  logic        w_accept;
  logic        w_isMul;
  logic        w_isDiv;
  logic        w_signedDiv;
  logic [31:0] w_absA;
  logic [31:0] w_absB;
  logic [63:0] w_mulA;
  logic [63:0] w_mulB;
  logic [63:0] w_product;
  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic        w_ge;
  logic [31:0] w_quoNext;
  logic [31:0] w_remNext;
  logic [31:0] w_quoFinal;
  logic [31:0] w_remFinal;

  assign w_accept    = req_valid & req_ready;
  assign w_isMul     = req_op[0] | req_op[1];
  assign w_isDiv     = req_op[2] | req_op[3];
  assign w_signedDiv = req_op[2];

  assign w_absA = (w_signedDiv & src_a[31]) ? (~src_a + 32'd1) : src_a;
  assign w_absB = (w_signedDiv & src_b[31]) ? (~src_b + 32'd1) : src_b;

  // Low 64 bits of the product of the extended operands give the signed or unsigned result.
  assign w_mulA    = {{32{r_mulSigned & r_opA[31]}}, r_opA};
  assign w_mulB    = {{32{r_mulSigned & r_opB[31]}}, r_opB};
  assign w_product = w_mulA * w_mulB;

  // r_opA doubles as the quotient shift register; the remainder stays below the divisor,
  // so bit 32 of the difference is set only when the trial subtraction goes negative.
  assign w_shift    = {r_rem, r_opA[31]};
  assign w_diff     = w_shift - {1'b0, r_opB};
  assign w_ge       = ~w_diff[32];
  assign w_remNext  = w_ge ? w_diff[31:0] : w_shift[31:0];
  assign w_quoNext  = {r_opA[30:0], w_ge};
  assign w_quoFinal = r_negQ ? (~w_quoNext + 32'd1) : w_quoNext;
  assign w_remFinal = r_negR ? (~w_remNext + 32'd1) : w_remNext;

  assign hi = r_hi;
  assign lo = r_lo;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    req_ready   = (r_state == IDLE) & ~flush;
    busy        = (r_state != IDLE);
    rd_data     = req_op[4] ? r_hi : r_lo;
    case (r_state)
      IDLE: begin
        if (w_accept & w_isMul)      w_nextState = MUL;
        else if (w_accept & w_isDiv) w_nextState = DIV;
      end
      MUL, DIV: begin
        if (flush || (r_cnt == 5'd0)) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi        <= 32'd0;
      r_lo        <= 32'd0;
      r_opA       <= 32'd0;
      r_opB       <= 32'd0;
      r_rem       <= 32'd0;
      r_rawA      <= 32'd0;
      r_cnt       <= 5'd0;
      r_mulSigned <= 1'b0;
      r_negQ      <= 1'b0;
      r_negR      <= 1'b0;
      r_divZero   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (req_op[6]) r_hi <= src_a;
            if (req_op[7]) r_lo <= src_a;
            if (w_isMul) begin
              r_opA       <= src_a;
              r_opB       <= src_b;
              r_mulSigned <= req_op[0];
              r_cnt       <= MUL_CNT_INIT;
            end
            if (w_isDiv) begin
              r_opA     <= w_absA;
              r_opB     <= w_absB;
              r_rem     <= 32'd0;
              r_rawA    <= src_a;
              r_negQ    <= w_signedDiv & (src_a[31] ^ src_b[31]);
              r_negR    <= w_signedDiv & src_a[31];
              r_divZero <= (src_b == 32'd0);
              r_cnt     <= 5'd31;
            end
          end
        end
        MUL: begin
          if (flush)                  r_cnt <= 5'd0;
          else if (r_cnt == 5'd0)     {r_hi, r_lo} <= w_product;
          else                        r_cnt <= r_cnt - 5'd1;
        end
        DIV: begin
          if (flush) begin
            r_cnt <= 5'd0;
          end else begin
            r_opA <= w_quoNext;
            r_rem <= w_remNext;
            if (r_cnt == 5'd0) begin
              r_hi <= r_divZero ? r_rawA : w_remFinal;
              r_lo <= r_divZero ? 32'hFFFF_FFFF : w_quoFinal;
            end else begin
              r_cnt <= r_cnt - 5'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed scenarios plus random operations
// compared against a plain-arithmetic model of HI/LO.
module tb_muldiv_ctrl;

  localparam int MUL_LAT = 2;

  localparam logic [7:0] OP_MULT  = 8'h01;
  localparam logic [7:0] OP_MULTU = 8'h02;
  localparam logic [7:0] OP_DIV   = 8'h04;
  localparam logic [7:0] OP_DIVU  = 8'h08;
  localparam logic [7:0] OP_MFHI  = 8'h10;
  localparam logic [7:0] OP_MFLO  = 8'h20;
  localparam logic [7:0] OP_MTHI  = 8'h40;
  localparam logic [7:0] OP_MTLO  = 8'h80;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        req_valid;
  logic [7:0]  req_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        req_ready;
  logic        busy;
  logic [31:0] rd_data;
  logic [31:0] hi;
  logic [31:0] lo;

  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] mHi = 32'd0;
  logic [31:0] mLo = 32'd0;

  always #5 clk = ~clk;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .req_valid (req_valid),
    .req_op    (req_op),
    .src_a     (src_a),
    .src_b     (src_b),
    .req_ready (req_ready),
    .busy      (busy),
    .rd_data   (rd_data),
    .hi        (hi),
    .lo        (lo)
  );

  // Reference: architectural {hi,lo} result computed with ordinary 64-bit arithmetic.
  function automatic logic [63:0] modelResult(input logic [7:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] p;
    logic [31:0] uq;
    logic [31:0] ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = 64'd0;
    if (op == OP_MULT) begin
      p = 64'(sa * sb);
    end else if (op == OP_MULTU) begin
      p = {32'd0, a} * {32'd0, b};
    end else if (b == 32'd0) begin
      p = {a, 32'hFFFF_FFFF};
    end else if (op == OP_DIV) begin
      q = sa / sb;
      r = sa % sb;
      p = {r[31:0], q[31:0]};
    end else begin
      uq = a / b;
      ur = a % b;
      p  = {ur, uq};
    end
    return p;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Presents one request for a single accept edge, then withdraws it.
  task automatic applyStimulus(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1;
    req_op    = op;
    src_a     = a;
    src_b     = b;
    tick();
    req_valid = 1'b0;
    req_op    = 8'd0;
  endtask

  task automatic runLong(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] expRes;
    int          lat;
    int          cycles;
    expRes = modelResult(op, a, b);
    lat    = (op == OP_MULT || op == OP_MULTU) ? MUL_LAT : 32;
    checkOutput("readyBeforeOp", 64'(req_ready), 64'd1);
    applyStimulus(op, a, b);
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      if (cycles == lat - 1) begin
        checkOutput("hiHeldBeforeWrite", 64'(hi), 64'(mHi));
        checkOutput("loHeldBeforeWrite", 64'(lo), 64'(mLo));
      end
      tick();
      cycles++;
    end
    checkOutput("busyCycles", 64'(cycles), 64'(lat));
    mHi = expRes[63:32];
    mLo = expRes[31:0];
    checkOutput("hiResult", 64'(hi), 64'(mHi));
    checkOutput("loResult", 64'(lo), 64'(mLo));
  endtask

  task automatic doMove(input logic [7:0] op, input logic [31:0] a);
    applyStimulus(op, a, 32'd0);
    if (op == OP_MTHI) mHi = a;
    else               mLo = a;
    checkOutput("moveHi", 64'(hi), 64'(mHi));
    checkOutput("moveLo", 64'(lo), 64'(mLo));
  endtask

  task automatic doRead(input logic [7:0] op);
    req_valid = 1'b1;
    req_op    = op;
    #1;
    checkOutput("readReady", 64'(req_ready), 64'd1);
    checkOutput("readData", 64'(rd_data), 64'((op == OP_MFHI) ? mHi : mLo));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = 8'd0;
    checkOutput("readKeepsLo", 64'(lo), 64'(mLo));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog timeout compared=%0d", compared);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          cycles;

    reset     = 1'b1;
    flush     = 1'b0;
    req_valid = 1'b0;
    req_op    = 8'd0;
    src_a     = 32'd0;
    src_b     = 32'd0;
    repeat (2) tick();
    reset = 1'b0;
    checkOutput("resetHi", 64'(hi), 64'd0);
    checkOutput("resetLo", 64'(lo), 64'd0);
    checkOutput("resetBusy", 64'(busy), 64'd0);
    checkOutput("resetReady", 64'(req_ready), 64'd1);

    runLong(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checkOutput("multuMaxHi", 64'(hi), 64'h0000_0000_FFFF_FFFE);

    // mult followed by an mflo held valid while the multiply is still running.
    applyStimulus(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    req_valid = 1'b1;
    req_op    = OP_MFLO;
    cycles    = 0;
    while (busy === 1'b1 && cycles < 100) begin
      checkOutput("stallReady", 64'(req_ready), 64'd0);
      tick();
      cycles++;
    end
    checkOutput("multBusyCycles", 64'(cycles), 64'(MUL_LAT));
    mHi = 32'hFFFF_FFFF;
    mLo = 32'hFFFF_FFF1;
    checkOutput("afterStallReady", 64'(req_ready), 64'd1);
    checkOutput("afterStallRd", 64'(rd_data), 64'(mLo));
    checkOutput("multHi", 64'(hi), 64'(mHi));
    tick();
    req_valid = 1'b0;
    req_op    = 8'd0;

    runLong(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    runLong(OP_DIVU, 32'd7, 32'd2);
    runLong(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    runLong(OP_DIVU, 32'h0000_1234, 32'd0);
    runLong(OP_DIV, 32'h8765_4321, 32'd0);
    doMove(OP_MTHI, 32'hA5A5_A5A5);
    doRead(OP_MFHI);

    // Flush part-way through a divide, then flush in IDLE with an mtlo pending.
    doMove(OP_MTHI, 32'd1);
    doMove(OP_MTLO, 32'd2);
    applyStimulus(OP_DIV, 32'd100, 32'd7);
    repeat (9) tick();
    flush = 1'b1;
    #1;
    checkOutput("flushDivReady", 64'(req_ready), 64'd0);
    tick();
    flush = 1'b0;
    checkOutput("flushDivBusy", 64'(busy), 64'd0);
    checkOutput("flushDivHi", 64'(hi), 64'd1);
    checkOutput("flushDivLo", 64'(lo), 64'd2);
    flush     = 1'b1;
    req_valid = 1'b1;
    req_op    = OP_MTLO;
    src_a     = 32'h55;
    #1;
    checkOutput("flushIdleReady", 64'(req_ready), 64'd0);
    tick();
    checkOutput("flushIdleLo", 64'(lo), 64'd2);
    flush = 1'b0;
    #1;
    checkOutput("postFlushReady", 64'(req_ready), 64'd1);
    tick();
    req_valid = 1'b0;
    req_op    = 8'd0;
    mLo       = 32'h55;
    checkOutput("postFlushMtlo", 64'(lo), 64'(mLo));

    // Flush landing on the completion edge of a multiply.
    applyStimulus(OP_MULTU, 32'd7, 32'd9);
    repeat (MUL_LAT - 1) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("flushDoneBusy", 64'(busy), 64'd0);
    checkOutput("flushDoneHi", 64'(hi), 64'(mHi));
    checkOutput("flushDoneLo", 64'(lo), 64'(mLo));

    // Reset in the middle of a divide.
    applyStimulus(OP_DIV, 32'd1000, 32'd3);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mHi   = 32'd0;
    mLo   = 32'd0;
    checkOutput("midResetHi", 64'(hi), 64'd0);
    checkOutput("midResetLo", 64'(lo), 64'd0);
    checkOutput("midResetBusy", 64'(busy), 64'd0);
    checkOutput("midResetReady", 64'(req_ready), 64'd1);
    runLong(OP_MULTU, 32'd3, 32'd4);
    checkOutput("multu3x4Lo", 64'(lo), 64'd12);

    for (int i = 0; i < 24; i++) begin
      op = 8'(1 << $urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 9));
        2: a = 32'h8000_0000;
        default: ;
      endcase
      if (op == OP_MTHI || op == OP_MTLO)      doMove(op, a);
      else if (op == OP_MFHI || op == OP_MFLO) doRead(op);
      else                                     runLong(op, a, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
